// File: rtl/ef_adc_sar_pkg.sv
// Shared types and constants for the EF 10-bit, 8-input SAR ADC controller.
package ef_adc_sar_pkg;

  localparam int ADC_BITS = 10;
  localparam int NUM_CH   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONV,
    S_DONE
  } state_t;

  typedef logic [2:0]          ch_t;
  typedef logic [ADC_BITS-1:0] code_t;

  // Index of the lowest set bit; scans run in ascending channel order.
  function automatic ch_t lowest_ch(input logic [NUM_CH-1:0] mask);
    ch_t idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = ch_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ef_adc_sar_core.sv
// Bit-trial engine: MSB-first binary search of the DAC code, each trial held
// SETTLE_CYCLES cycles before the comparator is taken. Runs while go is high.
module ef_adc_sar_core
  import ef_adc_sar_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                go,
  input  logic                cmp,
  output logic [ADC_BITS-1:0] data,
  output logic [ADC_BITS-1:0] code,
  output logic                fin
);

  localparam int           TW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(SETTLE_CYCLES - 1);
  localparam code_t        MSB   = code_t'(1) << (ADC_BITS - 1);

  code_t         kept;
  code_t         trial;
  logic [3:0]    step;
  logic [TW-1:0] cnt;
  logic          last;

  // step counts up from 0 so the tested bit index is ADC_BITS-1-step
  assign trial = MSB >> step;
  assign last  = (cnt == TLAST);
  assign data  = go ? (kept | trial) : '0;
  assign code  = cmp ? (kept | trial) : kept;
  assign fin   = go && last && (step == 4'(ADC_BITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kept <= '0;
      step <= '0;
      cnt  <= '0;
    end else if (!go) begin
      kept <= '0;
      step <= '0;
      cnt  <= '0;
    end else if (last) begin
      kept <= code;
      step <= step + 4'd1;
      cnt  <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/ef_adc_sar_ctrl.sv
// SAR ADC controller top: FSM, sample timing, channel select and start/done handshake.
// Define ADC_SAR_SEQ_EN to replace the single-channel `ch` input with a chan_mask scanner.
module ef_adc_sar_ctrl
  import ef_adc_sar_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
`ifdef ADC_SAR_SEQ_EN
  input  logic [NUM_CH-1:0]   chan_mask,
  output logic                scan_done,
`else
  input  logic [2:0]          ch,
`endif
  output logic                busy,
  output logic                done,
  output logic [ADC_BITS-1:0] result,
  output logic [2:0]          result_ch,
  output logic                hold,
  output logic                b0,
  output logic                b1,
  output logic                b2,
  output logic [ADC_BITS-1:0] data,
  input  logic                cmp
);

  localparam int            SW    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [SW-1:0] SLAST = SW'(SAMPLE_CYCLES - 1);

  state_t        state, state_n;
  logic [SW-1:0] smp_cnt;
  ch_t           ch_sel, first_ch;
  logic          accept, more, sample_last;
  logic          core_go, core_fin;
  code_t         core_code;

`ifdef ADC_SAR_SEQ_EN
  logic [NUM_CH-1:0] pend;
  ch_t               next_ch;

  assign first_ch = lowest_ch(chan_mask);
  assign next_ch  = lowest_ch(pend);
  assign accept   = (state == S_IDLE) && en && start && (chan_mask != '0);
  assign more     = (pend != '0);
`else
  assign first_ch = ch;
  assign accept   = (state == S_IDLE) && en && start;
  assign more     = 1'b0;
`endif

  assign sample_last  = (smp_cnt == SLAST);
  assign core_go      = (state == S_CONV);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign {b2, b1, b0} = ch_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!en) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (accept) state_n = S_SAMPLE;
        S_SAMPLE: if (sample_last) state_n = S_CONV;
        S_CONV:   if (core_fin) state_n = S_DONE;
        S_DONE:   state_n = more ? S_SAMPLE : S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // hold is high exactly while converting, so an abort or DONE drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt   <= '0;
      hold      <= 1'b0;
      ch_sel    <= '0;
      result    <= '0;
      result_ch <= '0;
`ifdef ADC_SAR_SEQ_EN
      pend      <= '0;
      scan_done <= 1'b0;
`endif
    end else begin
      smp_cnt <= (state == S_SAMPLE && state_n == S_SAMPLE) ? smp_cnt + SW'(1) : '0;
      hold    <= (state_n == S_CONV);
      if (accept) ch_sel <= first_ch;
      if (state == S_CONV && state_n == S_DONE) begin
        result    <= core_code;
        result_ch <= ch_sel;
      end
`ifdef ADC_SAR_SEQ_EN
      scan_done <= en && (state == S_DONE) && !more;
      if (!en) begin
        pend <= '0;
      end else if (accept) begin
        pend <= chan_mask & ~(NUM_CH'(1) << first_ch);
      end else if (state == S_DONE && more) begin
        ch_sel <= next_ch;
        pend   <= pend & ~(NUM_CH'(1) << next_ch);
      end
`endif
    end
  end

  ef_adc_sar_core #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .go  (core_go),
    .cmp (cmp),
    .data(data),
    .code(core_code),
    .fin (core_fin)
  );

endmodule

// File: tb/tb_ef_adc_sar_ctrl.sv
// Scoreboard bench for ef_adc_sar_ctrl: default-timing DUT plus a SAMPLE=1/SETTLE=1 DUT.
module tb_ef_adc_sar_ctrl;
  import ef_adc_sar_pkg::*;

  typedef struct {
    int code;
    int ch;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       start_f = 1'b0;
  logic       busy, done, hold, b0, b1, b2, cmp;
  logic       busy_f, done_f, hold_f, b0_f, b1_f, b2_f, cmp_f;
  logic [9:0] result, data, result_f, data_f;
  logic [2:0] result_ch, result_ch_f;
`ifdef ADC_SAR_SEQ_EN
  logic [7:0] chan_mask = '0;
  logic       scan_done, scan_done_f;
`else
  logic [2:0] ch = '0;
`endif

  int   thr_ch[8];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t fexp_q[$];
  int   dq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign cmp   = (int'(data) < thr_ch[{b2, b1, b0}]);
  assign cmp_f = (int'(data_f) < 601);

  ef_adc_sar_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
`ifdef ADC_SAR_SEQ_EN
    .chan_mask(chan_mask), .scan_done(scan_done),
`else
    .ch(ch),
`endif
    .busy(busy), .done(done), .result(result), .result_ch(result_ch),
    .hold(hold), .b0(b0), .b1(b1), .b2(b2), .data(data), .cmp(cmp)
  );

  ef_adc_sar_ctrl #(.SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut_f (
    .clk(clk), .rst(rst), .en(1'b1), .start(start_f),
`ifdef ADC_SAR_SEQ_EN
    .chan_mask(8'h20), .scan_done(scan_done_f),
`else
    .ch(3'd5),
`endif
    .busy(busy_f), .done(done_f), .result(result_f), .result_ch(result_ch_f),
    .hold(hold_f), .b0(b0_f), .b1(b1_f), .b2(b2_f), .data(data_f), .cmp(cmp_f)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_sel(input int ch_i);
`ifdef ADC_SAR_SEQ_EN
    chan_mask = 8'(1) << ch_i;
`else
    ch = 3'(ch_i);
`endif
  endtask

  task automatic convert(input int ch_i, input int t, input int exp_code, output int c0);
    for (int i = 0; i < 8; i++) thr_ch[i] = t;
    set_sel(ch_i);
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    if (exp_code >= 0) exp_q.push_back('{exp_code, ch_i, c0 + 29});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fexp_q.size() != 0 || busy || busy_f) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", int'(n < budget), 1);
  endtask

  always @(negedge clk) begin : mon_main
    exp_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.code);
        check("result_ch", result_ch, e.ch);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_fast
    exp_t e;
    if (done_f) begin
      if (fexp_q.size() == 0) begin
        check("fast_unexpected_done", 1, 0);
      end else begin
        e = fexp_q.pop_front();
        check("fast_result", result_f, e.code);
        check("fast_result_ch", result_ch_f, e.ch);
        check("fast_done_cycle", cyc, e.cyc);
      end
    end
    if (hold_f) begin
      if (dq.size() == 0) check("fast_unexpected_trial", 1, 0);
      else check("fast_trial_data", data_f, dq.pop_front());
    end
  end

  initial begin
    int c0;
    int tr[10];
    tr = '{512, 768, 640, 576, 608, 592, 600, 604, 602, 601};
    for (int i = 0; i < 8; i++) thr_ch[i] = 1024;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hold", hold, 0);
    check("rst_data", data, 0);
    check("rst_result", result, 0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal conversion: threshold 601 on channel 5
    convert(5, 601, 600, c0);
    wait_cyc(c0 + 1);
    check("sel_ch", {b2, b1, b0}, 5);
    check("busy_sample", busy, 1);
    wait_cyc(c0 + 8);
    check("hold_before_edge", hold, 0);
    wait_cyc(c0 + 9);
    check("hold_after_edge", hold, 1);
    check("first_trial", data, 512);
    wait_idle(100);
    check("idle_data", data, 0);

    // Asynchronous reset mid-conversion
    convert(2, 601, -1, c0);
    wait_cyc(c0 + 12);
    check("hold_mid_conv", hold, 1);
    rst = 1'b1;
    #1;
    check("arst_hold", hold, 0);
    check("arst_data", data, 0);
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    check("arst_sel", {b2, b1, b0}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Saturation at both ends
    convert(3, 0, 0, c0);
    wait_idle(100);
    convert(6, 1024, 1023, c0);
    wait_idle(100);

    // start while busy is ignored and the select stays put
    convert(5, 601, 600, c0);
    wait_cyc(c0 + 10);
    set_sel(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sel_stable", {b2, b1, b0}, 5);
    wait_idle(100);
    repeat (3) @(negedge clk);

    // en dropped mid-conversion aborts with no done and keeps the old result
    convert(1, 100, -1, c0);
    wait_cyc(c0 + 15);
    en = 1'b0;
    wait_cyc(c0 + 16);
    check("abort_busy", busy, 0);
    check("abort_hold", hold, 0);
    check("abort_data", data, 0);
    repeat (20) @(negedge clk);
    check("abort_result", result, 600);
    check("abort_result_ch", result_ch, 5);
    en = 1'b1;
    @(negedge clk);

`ifdef ADC_SAR_SEQ_EN
    // Scan of channels 1, 5, 7 with per-channel thresholds
    for (int i = 0; i < 8; i++) thr_ch[i] = 1024;
    thr_ch[1] = 100;
    thr_ch[5] = 200;
    thr_ch[7] = 300;
    chan_mask = 8'b1010_0010;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    exp_q.push_back('{99, 1, c0 + 29});
    exp_q.push_back('{199, 5, c0 + 58});
    exp_q.push_back('{299, 7, c0 + 87});
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c0 + 30);
    check("scan_sel_second", {b2, b1, b0}, 5);
    wait_cyc(c0 + 87);
    check("scan_done_early", scan_done, 0);
    wait_cyc(c0 + 88);
    check("scan_done_pulse", scan_done, 1);
    wait_cyc(c0 + 89);
    check("scan_done_clear", scan_done, 0);
    wait_idle(60);
    chan_mask = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("empty_mask_ignored", busy, 0);
`endif

    // Minimal timing: MSB-first search visible on the DAC code
    @(negedge clk);
    start_f = 1'b1;
    c0 = cyc;
    fexp_q.push_back('{600, 5, c0 + 12});
    for (int i = 0; i < 10; i++) dq.push_back(tr[i]);
    @(negedge clk);
    start_f = 1'b0;
    wait_idle(60);

    check("pending_results", exp_q.size() + fexp_q.size(), 0);
    check("pending_trials", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
